// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: stage-register enables, bubbles and PC enable.
// Optional performance counters are built only when PERF_COUNTERS_EN is defined.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  mem_branch_taken,
   input  logic                  imem_busy,
   input  logic                  dmem_busy,
   output logic                  pc_we,
   output logic                  ifid_we,
   output logic                  idex_we,
   output logic                  exmem_we,
   output logic                  memwb_we,
   output logic                  ifid_flush,
   output logic                  idex_flush,
   output logic                  exmem_flush,
   output logic [1:0]            ctrl_state,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      freeze_cnt
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LU_STALL   = 2'd1,
      BR_FLUSH   = 2'd2,
      MEM_FREEZE = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   load_use_raw, load_use;

   assign load_use_raw = ex_mem_read && (ex_rd != '0) &&
                         ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
   // The one-cycle stall/flush states already hold a bubble in the hazard slot.
   assign load_use     = load_use_raw && (state_q != LU_STALL) && (state_q != BR_FLUSH);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = RUN;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      if (dmem_busy) begin
         state_d = MEM_FREEZE;
      end else if (mem_branch_taken && (state_q != BR_FLUSH)) begin
         pc_we       = 1'b1;
         ifid_we     = 1'b1;
         idex_we     = 1'b1;
         exmem_we    = 1'b1;
         memwb_we    = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         state_d     = BR_FLUSH;
      end else if (load_use) begin
         // IF/ID simply holds, which also covers a concurrent fetch wait.
         idex_we    = 1'b1;
         idex_flush = 1'b1;
         exmem_we   = 1'b1;
         memwb_we   = 1'b1;
         state_d    = LU_STALL;
      end else if (imem_busy) begin
         ifid_we    = 1'b1;
         ifid_flush = 1'b1;
         idex_we    = 1'b1;
         exmem_we   = 1'b1;
         memwb_we   = 1'b1;
      end else begin
         pc_we    = 1'b1;
         ifid_we  = 1'b1;
         idex_we  = 1'b1;
         exmem_we = 1'b1;
         memwb_we = 1'b1;
      end
      if (areset) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_we    = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         exmem_flush = 1'b0;
      end
   end

   assign ctrl_state = state_q;

`ifdef PERF_COUNTERS_EN
   logic             fire_freeze, fire_flush, fire_stall;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, freeze_cnt_d;

   assign fire_freeze = dmem_busy;
   assign fire_flush  = !dmem_busy && mem_branch_taken && (state_q != BR_FLUSH);
   assign fire_stall  = !dmem_busy && !fire_flush && (load_use || imem_busy);

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      freeze_cnt_d = freeze_cnt_q;
      if (fire_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (fire_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
      if (fire_freeze && (freeze_cnt_q != '1)) begin
         freeze_cnt_d = freeze_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         freeze_cnt_q <= freeze_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign freeze_cnt = freeze_cnt_q;
`else
   assign stall_cnt  = '0;
   assign flush_cnt  = '0;
   assign freeze_cnt = '0;
`endif

endmodule
